multicycle_control: RTL and testbench

Multicycle control unit that sequences the shared single-ALU, single-memory MIPS datapath: one ALU, one unified memory, register file, and PC/IR/ALUOut/MDR holding registers. A Moore state machine walks each instruction through fetch, decode, execute, memory and write-back. It emits every datapath select and write strobe in the ALU's native 3-bit op encoding. It also keeps a retired-instruction counter and a sticky illegal-instruction halt.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS controller.
// master = control unit, slave = datapath (IR fields + zero flag in, selects/strobes out).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;

  modport master (
    input  opcode, func, zero,
    output pc_en, pc_src, ir_write,
    output mem_read, mem_write, iord,
    output reg_write, reg_dst, mem_to_reg,
    output alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    output opcode, func, zero,
    input  pc_en, pc_src, ir_write,
    input  mem_read, mem_write, iord,
    input  reg_write, reg_dst, mem_to_reg,
    input  alu_src_a, alu_src_b, alu_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared-ALU multicycle MIPS datapath.
// Ports: clk, reset (sync, high), bus (controls), state, retired, illegal.
module multicycle_control #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_control_if.master bus,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_r, is_mem, is_beq, is_j, is_addi;
  logic func_ok;
  logic [2:0] r_op;
  logic term;

  assign is_r    = bus.opcode == 6'b000000;
  assign is_mem  = bus.opcode == 6'b100011
                || bus.opcode == 6'b101011;
  assign is_beq  = bus.opcode == 6'b000100;
  assign is_j    = bus.opcode == 6'b000010;
  assign is_addi = bus.opcode == 6'b001000;

  always_comb begin
    func_ok = 1'b1;
    r_op    = 3'b010;
    case (bus.func)
      6'b100000: r_op = 3'b010;
      6'b100010: r_op = 3'b110;
      6'b100100: r_op = 3'b000;
      6'b100101: r_op = 3'b001;
      6'b101010: r_op = 3'b111;
      default:   func_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:            state_d = S_MEM_ADDR;
          is_r && func_ok:   state_d = S_R_EXEC;
          is_beq:            state_d = S_BRANCH;
          is_j:              state_d = S_JUMP;
          is_addi:           state_d = S_ADDI_EXEC;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:
        state_d = bus.opcode[3] ? S_MEM_WRITE
                                : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Terminal states retire on the edge that leaves them.
  always_comb begin
    case (state_q)
      S_MEM_WB, S_MEM_WRITE, S_R_WB,
      S_BRANCH, S_JUMP, S_ADDI_WB: term = 1'b1;
      default:                     term = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (term)
        retired <= retired + COUNT_W'(1);
    end
  end

  assign state   = state_q;
  assign illegal = state_q == S_HALT;

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 3'b000;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = 1'b1;
        bus.pc_en     = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b010;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_op    = 3'b010;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 3'b010;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = r_op;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_ADDI_WB: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b110;
        bus.pc_src    = 2'b01;
        bus.pc_en     = bus.zero;
      end
      S_JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_en  = 1'b1;
      end
      default: ;
    endcase
    // A stale state during reset must not write anything.
    if (reset) begin
      bus.pc_en     = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (COUNT_W=4 to reach wrap).
// Expected per-cycle state/controls are queued per instruction, then popped.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] state;
  logic [3:0] retired;
  logic illegal;

  multicycle_control_if bus();

  multicycle_control #(.COUNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state   (state),
    .retired (retired),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         st;
    logic [16:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] model_ret = 4'd0;

  logic [16:0] obs;
  assign obs = {bus.pc_en, bus.pc_src, bus.ir_write,
                bus.mem_read, bus.mem_write, bus.iord,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                illegal};

  function automatic logic [16:0] exp_ctrl(int st,
      logic [5:0] fn, logic z);
    logic pe, irw, mr, mw, io, rw, rd, m2r, sa, ill;
    logic [1:0] ps, sbv;
    logic [2:0] op;
    {pe, irw, mr, mw, io, rw, rd, m2r, sa, ill} = '0;
    ps = 2'b00; sbv = 2'b00; op = 3'b000;
    case (st)
      0: begin pe = 1; irw = 1; mr = 1; sbv = 2'b01; op = 3'b010; end
      1: begin sbv = 2'b11; op = 3'b010; end
      2, 10: begin sa = 1; sbv = 2'b10; op = 3'b010; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; io = 1; end
      6: begin
        sa = 1;
        case (fn)
          6'b100000: op = 3'b010;
          6'b100010: op = 3'b110;
          6'b100100: op = 3'b000;
          6'b100101: op = 3'b001;
          6'b101010: op = 3'b111;
          default:   op = 3'bxxx;
        endcase
      end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; op = 3'b110; ps = 2'b01; pe = z; end
      9: begin ps = 2'b10; pe = 1; end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pe, ps, irw, mr, mw, io, rw, rd, m2r, sa, sbv, op, ill};
  endfunction

  task automatic push(int st, logic [5:0] fn, logic z);
    exp_t e;
    e.st = st;
    e.ctrl = exp_ctrl(st, fn, z);
    sb.push_back(e);
  endtask

  // Queue the expected state walk; returns 1 if the instruction retires.
  task automatic push_path(logic [5:0] op, logic [5:0] fn,
      logic z, output bit retires);
    retires = 1'b1;
    push(0, fn, z);
    push(1, fn, z);
    case (op)
      6'b100011: begin push(2, fn, z); push(3, fn, z); push(4, fn, z); end
      6'b101011: begin push(2, fn, z); push(5, fn, z); end
      6'b000100: push(8, fn, z);
      6'b000010: push(9, fn, z);
      6'b001000: begin push(10, fn, z); push(11, fn, z); end
      6'b000000: begin
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
            fn == 6'b100101 || fn == 6'b101010) begin
          push(6, fn, z); push(7, fn, z);
        end else begin
          push(12, fn, z); retires = 1'b0;
        end
      end
      default: begin push(12, fn, z); retires = 1'b0; end
    endcase
  endtask

  task automatic drain(string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      checks++;
      if (state !== 4'(e.st) || obs !== e.ctrl) begin
        errors++;
        $display("FAIL %s: state %0d ctrl %b, required state %0d ctrl %b",
                 name, state, obs, e.st, e.ctrl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_ret(string name);
    checks++;
    if (retired !== model_ret) begin
      errors++;
      $display("FAIL %s retired: got %0d required %0d",
               name, retired, model_ret);
    end
  endtask

  task automatic run_instr(string name, logic [5:0] op,
      logic [5:0] fn, logic z);
    bit r;
    bus.opcode = op;
    bus.func = fn;
    bus.zero = z;
    push_path(op, fn, z, r);
    drain(name);
    if (r) model_ret = model_ret + 4'd1;
    if (r) check_ret(name);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 4'd0;
  endtask

  task automatic test_reset();
    bus.opcode = 6'b000000;
    bus.func = 6'b100000;
    bus.zero = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || retired !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: state %0d retired %0d illegal %b, required 0 0 0",
               state, retired, illegal);
    end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    foreach (fns[i]) run_instr("rtype", 6'b000000, fns[i], 1'b0);
  endtask

  task automatic test_mem();
    run_instr("lw", 6'b100011, 6'b000000, 1'b0);
    run_instr("sw", 6'b101011, 6'b101010, 1'b0);
    run_instr("addi", 6'b001000, 6'b111111, 1'b1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1);
    run_instr("beq_not", 6'b000100, 6'b000000, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000100;
        3: op = 6'b000010;
        4: op = 6'b001000;
        default: op = 6'b000000;
      endcase
      run_instr("b2b", op, 6'b100101, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_illegal(logic [5:0] op, logic [5:0] fn);
    run_instr("illegal", op, fn, 1'b0);
    for (int i = 0; i < 19; i++) push(12, fn, 1'b0);
    drain("halt_hold");
    check_ret("halt_no_count");
    do_reset();
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: state %0d illegal %b, required 0 0",
               state, illegal);
    end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_reset_mid();
    run_instr("pre_mid", 6'b000010, 6'b000000, 1'b0);
    bus.opcode = 6'b101011;
    push(0, 6'b0, 1'b0);
    push(1, 6'b0, 1'b0);
    push(2, 6'b0, 1'b0);
    drain("mid_sw");
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 4'd5 || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_strobe: state %0d mem_write %b, required 5 0",
               state, bus.mem_write);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 4'd0;
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_after: state %0d retired %0d, required 0 0",
               state, retired);
    end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 16; i++) begin
      run_instr("wrap_j", 6'b000010, 6'b000000, 1'b0);
      if (i == 15) begin
        checks++;
        if (retired !== 4'd15) begin
          errors++;
          $display("FAIL wrap15: got %0d required 15", retired);
        end
      end
      if (i == 16) begin
        checks++;
        if (retired !== 4'd0) begin
          errors++;
          $display("FAIL wrap0: got %0d required 0", retired);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'b0;
    bus.func = 6'b0;
    bus.zero = 1'b0;
    test_reset();
    test_rtype();
    test_mem();
    test_beq();
    test_back_to_back();
    test_illegal(6'b000000, 6'b100111);
    test_illegal(6'b111111, 6'b100000);
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
